// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: function codes, opcodes, FSM states
// and the instruction decoder.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  // op field 0000 selects the register form; the ext field then carries the opcode
  localparam logic [3:0] OP_REG  = 4'b0000;
  localparam logic [3:0] OPC_ADD = 4'b0101;
  localparam logic [3:0] OPC_SUB = 4'b1001;
  localparam logic [3:0] OPC_AND = 4'b0001;
  localparam logic [3:0] OPC_OR  = 4'b0010;
  localparam logic [3:0] OPC_XOR = 4'b0011;
  localparam logic [3:0] OPC_MOV = 4'b1101;
  localparam logic [3:0] OPC_CMP = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       imm_form;
    logic       sext;
    logic       we;
    logic       mov;
    logic [2:0] alucont;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] instr);
    dec_t       d;
    logic [3:0] code;
    d          = '0;
    d.imm_form = (instr[15:12] != OP_REG);
    code       = d.imm_form ? instr[15:12] : instr[7:4];
    d.legal    = 1'b1;
    d.we       = 1'b1;
    case (code)
      OPC_ADD: begin d.alucont = ALU_ADD; d.sext = 1'b1; end
      OPC_SUB: begin d.alucont = ALU_SUB; d.sext = 1'b1; end
      OPC_AND: d.alucont = ALU_AND;
      OPC_OR:  d.alucont = ALU_OR;
      OPC_XOR: d.alucont = ALU_XOR;
      OPC_MOV: d.mov = 1'b1;
      OPC_CMP: begin
        // CMP exists only in register form; its opcode value is not an immediate op
        if (d.imm_form) begin
          d.legal = 1'b0;
          d.we    = 1'b0;
        end else begin
          d.alucont = ALU_SUB;
          d.we      = 1'b0;
        end
      end
      default: begin
        d.legal = 1'b0;
        d.we    = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile16.sv
// 16-entry register file: two combinational read ports, a debug read port and one
// synchronous write port, cleared by synchronous reset.
module regfile16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [3:0]       i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [3:0]       i_raddr_a,
  input  logic [3:0]       i_raddr_b,
  input  logic [3:0]       i_dbg_addr,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b,
  output logic [WIDTH-1:0] o_dbg_data
);

  logic [WIDTH-1:0] r_mem [16];

  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue stage feeding a combinational 16-bit ALU: decode, operand fetch, and
// write-back through a fixed IDLE -> EXEC -> WB sequence.
module alu_issue #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alucont,
  input  logic [WIDTH-1:0] alu_result,
  output logic             done,
  output logic             illegal,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  import alu_pkg::*;

  state_t           r_state;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_wb_data;
  logic [2:0]       r_alucont;
  logic [3:0]       r_dest;
  logic             r_we;
  logic             r_mov;
  logic             r_ill_pend;
  logic             r_done;
  logic             r_illegal;

  dec_t             w_dec;
  logic [WIDTH-1:0] w_rdata_a;
  logic [WIDTH-1:0] w_rdata_b;
  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_op_b;
  logic             w_wr_en;

  assign w_dec     = decode(instr);
  assign w_imm_ext = w_dec.sext ? {{(WIDTH-8){instr[7]}}, instr[7:0]}
                                : {{(WIDTH-8){1'b0}}, instr[7:0]};
  assign w_op_b    = w_dec.imm_form ? w_imm_ext : w_rdata_b;
  assign w_wr_en   = (r_state == WB) && r_we;

  regfile16 #(.WIDTH(WIDTH)) u_rf (
    .clk        (clk),
    .i_reset    (reset),
    .i_we       (w_wr_en),
    .i_waddr    (r_dest),
    .i_wdata    (r_wb_data),
    .i_raddr_a  (instr[11:8]),
    .i_raddr_b  (instr[3:0]),
    .i_dbg_addr (dbg_addr),
    .o_rdata_a  (w_rdata_a),
    .o_rdata_b  (w_rdata_b),
    .o_dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_wb_data  <= '0;
      r_alucont  <= ALU_AND;
      r_dest     <= '0;
      r_we       <= 1'b0;
      r_mov      <= 1'b0;
      r_ill_pend <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done    <= 1'b0;
          r_illegal <= 1'b0;
          if (in_valid) begin
            r_alu_a    <= w_rdata_a;
            r_alu_b    <= w_op_b;
            r_alucont  <= w_dec.alucont;
            r_dest     <= instr[11:8];
            r_we       <= w_dec.we;
            r_mov      <= w_dec.mov;
            r_ill_pend <= ~w_dec.legal;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          // MOV/MOVI bypass the ALU and retire the latched second operand
          r_wb_data <= r_mov ? r_alu_b : alu_result;
          r_done    <= 1'b1;
          r_illegal <= r_ill_pend;
          r_state   <= WB;
        end
        WB: begin
          r_done    <= 1'b0;
          r_illegal <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == IDLE) && !reset;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alucont  = r_alucont;
  assign done     = r_done;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table, back-to-back and reset corner cases,
// and random instructions checked against a register-file reference model.
module tb_alu_issue;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [15:0]  instr = '0;
  logic         in_ready;
  logic [W-1:0] alu_a, alu_b, alu_result, dbg_data;
  logic [2:0]   alucont;
  logic         done, illegal;
  logic [3:0]   dbg_addr = '0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] ref_rf [16];

  typedef struct {
    logic [15:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  cont;
    logic        ill;
    logic [3:0]  reg_idx;
    logic [15:0] reg_val;
    logic        chk_ab;
    logic        chk_cont;
  } vec_t;

  vec_t vec [15];

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alucont    (alucont),
    .alu_result (alu_result),
    .done       (done),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Behavioural ALU driven by the DUT's registered operands
  always_comb begin
    alu_result = '0;
    case (alucont)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a + alu_b;
      3'b110: alu_result = alu_a - alu_b;
      3'b111: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic dbg_read(input logic [3:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Instruction semantics straight from the ISA description, applied to ref_rf
  function automatic void model(input logic [15:0] w, output logic legal, output logic is_mov,
                                output logic wr, output logic [15:0] a, output logic [15:0] b,
                                output logic [2:0] cont, output logic [15:0] wdata);
    logic       is_reg;
    logic [3:0] code;
    logic [7:0] imm;
    is_reg = (w[15:12] == 4'h0);
    code   = is_reg ? w[7:4] : w[15:12];
    imm    = w[7:0];
    a      = ref_rf[w[11:8]];
    if (is_reg) b = ref_rf[w[3:0]];
    else if (code == 4'd5 || code == 4'd9) b = {{8{imm[7]}}, imm};
    else b = {8'h00, imm};
    legal = 1'b1; is_mov = 1'b0; wr = 1'b1; cont = 3'b000; wdata = '0;
    case (code)
      4'd5:  begin cont = 3'b010; wdata = a + b; end
      4'd9:  begin cont = 3'b110; wdata = a - b; end
      4'd1:  begin cont = 3'b000; wdata = a & b; end
      4'd2:  begin cont = 3'b001; wdata = a | b; end
      4'd3:  begin cont = 3'b111; wdata = a ^ b; end
      4'd13: begin is_mov = 1'b1; wdata = b; end
      4'd11: begin
        wr = 1'b0;
        if (is_reg) cont = 3'b110;
        else legal = 1'b0;
      end
      default: begin legal = 1'b0; wr = 1'b0; end
    endcase
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", in_ready, 1);
  endtask

  // One full transaction: accept, EXEC, WB, retire; every observable checked against the model
  task automatic run_instr(input logic [15:0] w, output logic [15:0] ga, output logic [15:0] gb,
                           output logic [2:0] gc, output logic gi);
    logic legal, is_mov, wr;
    logic [15:0] ea, eb, wd, old, v;
    logic [2:0] ec;
    logic [3:0] rd;
    model(w, legal, is_mov, wr, ea, eb, ec, wd);
    rd  = w[11:8];
    old = ref_rf[rd];
    wait_ready();
    instr = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ga = alu_a; gb = alu_b; gc = alucont;
    if (legal) begin
      check("alu_a", alu_a, ea);
      check("alu_b", alu_b, eb);
    end
    if (!is_mov) check("alucont", alucont, ec);
    check("exec_done", done, 0);
    check("exec_ready", in_ready, 0);
    @(posedge clk);
    #1;
    gi = illegal;
    check("wb_done", done, 1);
    check("wb_illegal", illegal, !legal);
    check("wb_ready", in_ready, 0);
    dbg_read(rd, v);
    check("wb_old_value", v, old);
    @(posedge clk);
    #1;
    check("idle_done", done, 0);
    check("idle_illegal", illegal, 0);
    check("idle_ready", in_ready, 1);
    if (wr) ref_rf[rd] = wd;
    dbg_read(rd, v);
    check("rf_writeback", v, ref_rf[rd]);
    $display("instr %04h a=%04h b=%04h cont=%03b illegal=%0b r%0d=%04h", w, ga, gb, gc, gi, rd, v);
  endtask

  task automatic check_all_zero(input string name);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) begin
      dbg_read(i[3:0], v);
      check(name, v, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ga, gb, w, v;
    logic [2:0]  gc;
    logic        gi;
    logic [3:0]  codes [7];

    vec[0]  = '{16'hD385, 16'h0000, 16'h0085, 3'b000, 1'b0, 4'd3,  16'h0085, 1'b1, 1'b0};
    vec[1]  = '{16'h53FF, 16'h0085, 16'hFFFF, 3'b010, 1'b0, 4'd3,  16'h0084, 1'b1, 1'b1};
    vec[2]  = '{16'hD205, 16'h0000, 16'h0005, 3'b000, 1'b0, 4'd2,  16'h0005, 1'b1, 1'b0};
    vec[3]  = '{16'hD107, 16'h0000, 16'h0007, 3'b000, 1'b0, 4'd1,  16'h0007, 1'b1, 1'b0};
    vec[4]  = '{16'h0251, 16'h0005, 16'h0007, 3'b010, 1'b0, 4'd2,  16'h000C, 1'b1, 1'b1};
    vec[5]  = '{16'h02B1, 16'h000C, 16'h0007, 3'b110, 1'b0, 4'd2,  16'h000C, 1'b1, 1'b1};
    vec[6]  = '{16'hF123, 16'h0000, 16'h0000, 3'b000, 1'b1, 4'd1,  16'h0007, 1'b0, 1'b1};
    vec[7]  = '{16'h3280, 16'h000C, 16'h0080, 3'b111, 1'b0, 4'd2,  16'h008C, 1'b1, 1'b1};
    vec[8]  = '{16'h9301, 16'h0084, 16'h0001, 3'b110, 1'b0, 4'd3,  16'h0083, 1'b1, 1'b1};
    vec[9]  = '{16'h1F0F, 16'h0000, 16'h000F, 3'b000, 1'b0, 4'd15, 16'h0000, 1'b1, 1'b1};
    vec[10] = '{16'h0DD3, 16'h0000, 16'h0083, 3'b000, 1'b0, 4'd13, 16'h0083, 1'b1, 1'b0};
    vec[11] = '{16'h0B42, 16'h0000, 16'h0000, 3'b000, 1'b1, 4'd11, 16'h0000, 1'b0, 1'b1};
    vec[12] = '{16'h2A9F, 16'h0000, 16'h009F, 3'b001, 1'b0, 4'd10, 16'h009F, 1'b1, 1'b1};
    vec[13] = '{16'h0A93, 16'h009F, 16'h0083, 3'b110, 1'b0, 4'd10, 16'h001C, 1'b1, 1'b1};
    vec[14] = '{16'h99F0, 16'h0000, 16'hFFF0, 3'b110, 1'b0, 4'd9,  16'h0010, 1'b1, 1'b1};
    codes = '{4'd5, 4'd9, 4'd1, 4'd2, 4'd3, 4'd13, 4'd11};
    for (int i = 0; i < 16; i++) ref_rf[i] = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_low", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_ready", in_ready, 1);
    check("reset_done", done, 0);
    check("reset_alucont", alucont, 0);
    check_all_zero("reset_rf");

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      run_instr(vec[i].instr, ga, gb, gc, gi);
      if (vec[i].chk_ab) begin
        check("tbl_alu_a", ga, vec[i].a);
        check("tbl_alu_b", gb, vec[i].b);
      end
      if (vec[i].chk_cont) check("tbl_alucont", gc, vec[i].cont);
      check("tbl_illegal", gi, vec[i].ill);
      dbg_read(vec[i].reg_idx, v);
      check("tbl_reg", v, vec[i].reg_val);
    end

    // in_valid held across two back-to-back words: each consumed exactly once
    wait_ready();
    instr = 16'hD1AA;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_exec_ready", in_ready, 0);
    check("b2b_first_b", alu_b, 16'h00AA);
    instr = 16'h5101;
    @(posedge clk); #1;
    check("b2b_wb_ready", in_ready, 0);
    check("b2b_wb_done", done, 1);
    @(posedge clk); #1;
    check("b2b_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_second_a", alu_a, 16'h00AA);
    check("b2b_second_b", alu_b, 16'h0001);
    check("b2b_second_cont", alucont, 3'b010);
    @(posedge clk); #1;
    check("b2b_second_done", done, 1);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("b2b_no_rerun", done, 0);
    end
    dbg_read(4'd1, v);
    check("b2b_r1", v, 16'h00AB);
    ref_rf[1] = 16'h00AB;

    // Random instructions against the reference model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        w = 16'($urandom);
      end else if ($urandom_range(0, 1) == 1) begin
        w = {4'h0, 4'($urandom_range(0, 15)), codes[$urandom_range(0, 6)], 4'($urandom_range(0, 15))};
      end else begin
        w = {codes[$urandom_range(0, 6)], 4'($urandom_range(0, 15)), 8'($urandom)};
      end
      run_instr(w, ga, gb, gc, gi);
    end

    // Reset asserted in EXEC discards the pending write
    wait_ready();
    instr = 16'hD455;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_exec_b", alu_b, 16'h0055);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alucont", alucont, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_idle_ready", in_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_no_done", done, 0);
    end
    check_all_zero("rst_rf");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
